// File: rtl/pb_field_sequencer.sv
// pb_field_sequencer: walks a protobuf message through an external key decoder,
// emitting one header plus a payload byte stream per field.
// Ports: clock/reset (async active-low); msg_start/msg_len start a message;
// in_* byte stream in; dec_input_0..3 window out, dec_* decoder results in;
// hdr_* field header out; pay_* payload bytes out; busy/done/err/err_code status.
// Optional macro FIELD_FILTER_EN adds filter_en/filter_field to drop
// non-matching fields internally.
module pb_field_sequencer #(
    parameter int MAX_VARINT_BYTES = 10,
    parameter int LEN_W            = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             msg_start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       dec_input_0,
    output logic [7:0]       dec_input_1,
    output logic [7:0]       dec_input_2,
    output logic [7:0]       dec_input_3,
    input  logic [2:0]       dec_wire_type,
    input  logic [7:0]       dec_field_number,
    input  logic [7:0]       dec_bytes_read,
    input  logic [15:0]      dec_value_size,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic [7:0]       hdr_field,
    output logic [2:0]       hdr_wire,
    output logic [LEN_W-1:0] hdr_len,
    output logic             pay_valid,
    input  logic             pay_ready,
    output logic [7:0]       pay_data,
    output logic             pay_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
`ifdef FIELD_FILTER_EN
    ,
    input  logic             filter_en,
    input  logic [7:0]       filter_field
`endif
);

    localparam int VCNT_W = $clog2(MAX_VARINT_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DECODE,
        S_HDR,
        S_PAYLOAD,
        S_NEXT,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [3:0][7:0]    win_q, win_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   fld_q, fld_d;
    logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
    logic               varint_q, varint_d;
    logic               fwd_q, fwd_d;
    logic               sent_q, sent_d;
    logic               hdr_valid_q, hdr_valid_d;
    logic [7:0]         hdr_field_q, hdr_field_d;
    logic [2:0]         hdr_wire_q, hdr_wire_d;
    logic [LEN_W-1:0]   hdr_len_q, hdr_len_d;
    logic               pay_valid_q, pay_valid_d;
    logic [7:0]         pay_data_q, pay_data_d;
    logic               pay_last_q, pay_last_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;

    logic [LEN_W-1:0]   cnt_l, br_l, rem_key, fix_len, target;
    logic               bad_key, bad_wire, overrun, fwd;
    logic               src_win, load_ok, active, take, is_last, v_over;
    logic [7:0]         take_byte;

    always_comb begin
        cnt_l    = LEN_W'(cnt_q);
        br_l     = LEN_W'(dec_bytes_read);
        rem_key  = rem_q - br_l;
        target   = (rem_q < LEN_W'(4)) ? rem_q : LEN_W'(4);
        bad_key  = (dec_bytes_read == 8'd0) || (br_l > cnt_l) || (br_l > rem_q);
        bad_wire = (dec_wire_type == 3'd3) || (dec_wire_type == 3'd4) ||
                   (dec_wire_type == 3'd6) || (dec_wire_type == 3'd7);
        fix_len  = '0;
        case (dec_wire_type)
            3'd1:    fix_len = LEN_W'(8);
            3'd2:    fix_len = LEN_W'(dec_value_size);
            3'd5:    fix_len = LEN_W'(4);
            default: fix_len = '0;
        endcase
        // a varint needs at least one byte; fixed lengths must fit the message
        overrun  = (dec_wire_type == 3'd0) ? (rem_key == '0) : (fix_len > rem_key);
`ifdef FIELD_FILTER_EN
        fwd      = !filter_en || (dec_field_number == filter_field);
`else
        fwd      = 1'b1;
`endif
        // payload source: leftover window bytes before fresh input bytes
        src_win   = (cnt_q != 3'd0);
        load_ok   = fwd_q ? (!pay_valid_q || pay_ready) : 1'b1;
        active    = (state_q == S_PAYLOAD) && !sent_q;
        take_byte = src_win ? win_q[0] : in_data;
        take      = active && load_ok && (src_win || in_valid);
        is_last   = varint_q ? !take_byte[7] : (fld_q == LEN_W'(1));
        v_over    = varint_q && take_byte[7] &&
                    ((int'(vcnt_q) + 1 >= MAX_VARINT_BYTES) || (rem_q == LEN_W'(1)));
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        fld_d       = fld_q;
        vcnt_d      = vcnt_q;
        varint_d    = varint_q;
        fwd_d       = fwd_q;
        sent_d      = sent_q;
        hdr_valid_d = hdr_valid_q;
        hdr_field_d = hdr_field_q;
        hdr_wire_d  = hdr_wire_q;
        hdr_len_d   = hdr_len_q;
        pay_valid_d = pay_valid_q;
        pay_data_d  = pay_data_q;
        pay_last_d  = pay_last_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;
        in_ready    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (msg_start) begin
                    rem_d      = msg_len;
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    if (msg_len == '0) done_d  = 1'b1;
                    else               state_d = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = (cnt_l < target);
                if (in_valid && in_ready) begin
                    win_d[cnt_q[1:0]] = in_data;
                    cnt_d             = cnt_q + 3'd1;
                end
                if (cnt_l == target) state_d = S_DECODE;
            end
            S_DECODE: begin
                hdr_field_d = dec_field_number;
                hdr_wire_d  = dec_wire_type;
                hdr_len_d   = fix_len;
                if (bad_key) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd1;
                end else if (bad_wire) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd2;
                end else if (overrun) begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end else begin
                    win_d    = win_q >> {dec_bytes_read[2:0], 3'b000};
                    cnt_d    = cnt_q - dec_bytes_read[2:0];
                    rem_d    = rem_key;
                    fld_d    = fix_len;
                    varint_d = (dec_wire_type == 3'd0);
                    vcnt_d   = '0;
                    sent_d   = 1'b0;
                    fwd_d    = fwd;
                    if (fwd) begin
                        hdr_valid_d = 1'b1;
                        state_d     = S_HDR;
                    end else if (fix_len == '0 && dec_wire_type != 3'd0) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_HDR: begin
                if (hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    state_d = (hdr_len_q == '0 && !varint_q) ? S_NEXT : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                in_ready = !sent_q && load_ok && !src_win;
                if (pay_valid_q && pay_ready) begin
                    pay_valid_d = 1'b0;
                    pay_last_d  = 1'b0;
                    if (pay_last_q) state_d = S_NEXT;
                end
                if (take) begin
                    if (src_win) begin
                        win_d = win_q >> 8;
                        cnt_d = cnt_q - 3'd1;
                    end
                    rem_d  = rem_q - LEN_W'(1);
                    vcnt_d = vcnt_q + VCNT_W'(1);
                    if (!varint_q) fld_d = fld_q - LEN_W'(1);
                    if (v_over) begin
                        state_d    = S_ERR;
                        err_code_d = 2'd3;
                    end else begin
                        if (is_last) sent_d = 1'b1;
                        if (fwd_q) begin
                            pay_valid_d = 1'b1;
                            pay_data_d  = take_byte;
                            pay_last_d  = is_last;
                        end else if (is_last) begin
                            state_d = S_NEXT;
                        end
                    end
                end
            end
            S_NEXT: begin
                if (rem_q != '0) begin
                    state_d = S_FILL;
                end else if (cnt_q == 3'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_ERR;
                    err_code_d = 2'd3;
                end
            end
            S_ERR: begin
                // rem_q now counts message bytes still owed by the source
                in_ready = (rem_q != '0);
                if (in_valid && in_ready) rem_d = rem_q - LEN_W'(1);
                if (rem_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // on entry to ERR, window bytes are dropped and only unreceived bytes are drained
        if (state_d == S_ERR && state_q != S_ERR) begin
            err_d       = 1'b1;
            rem_d       = rem_d - LEN_W'(cnt_d);
            cnt_d       = 3'd0;
            win_d       = '0;
            hdr_valid_d = 1'b0;
            pay_valid_d = 1'b0;
            pay_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            fld_q       <= '0;
            vcnt_q      <= '0;
            varint_q    <= 1'b0;
            fwd_q       <= 1'b0;
            sent_q      <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_field_q <= '0;
            hdr_wire_q  <= '0;
            hdr_len_q   <= '0;
            pay_valid_q <= 1'b0;
            pay_data_q  <= '0;
            pay_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            fld_q       <= fld_d;
            vcnt_q      <= vcnt_d;
            varint_q    <= varint_d;
            fwd_q       <= fwd_d;
            sent_q      <= sent_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_field_q <= hdr_field_d;
            hdr_wire_q  <= hdr_wire_d;
            hdr_len_q   <= hdr_len_d;
            pay_valid_q <= pay_valid_d;
            pay_data_q  <= pay_data_d;
            pay_last_q  <= pay_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign dec_input_0 = win_q[0];
    assign dec_input_1 = win_q[1];
    assign dec_input_2 = win_q[2];
    assign dec_input_3 = win_q[3];
    assign hdr_valid   = hdr_valid_q;
    assign hdr_field   = hdr_field_q;
    assign hdr_wire    = hdr_wire_q;
    assign hdr_len     = hdr_len_q;
    assign pay_valid   = pay_valid_q;
    assign pay_data    = pay_data_q;
    assign pay_last    = pay_last_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_pb_field_sequencer.sv
// tb_pb_field_sequencer: directed bench for pb_field_sequencer with a small
// single-byte-key decoder model and hand-computed expected fields.
module tb_pb_field_sequencer;

    localparam int LEN_W = 16;

    logic             clock;
    logic             reset;
    logic             msg_start;
    logic [LEN_W-1:0] msg_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [7:0]       dec_input_0, dec_input_1, dec_input_2, dec_input_3;
    logic [2:0]       dec_wire_type;
    logic [7:0]       dec_field_number;
    logic [7:0]       dec_bytes_read;
    logic [15:0]      dec_value_size;
    logic             hdr_valid, hdr_ready;
    logic [7:0]       hdr_field;
    logic [2:0]       hdr_wire;
    logic [LEN_W-1:0] hdr_len;
    logic             pay_valid, pay_ready, pay_data_unused;
    logic [7:0]       pay_data;
    logic             pay_last;
    logic             busy, done, err;
    logic [1:0]       err_code;

    pb_field_sequencer #(.MAX_VARINT_BYTES(10), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset(reset),
        .msg_start(msg_start), .msg_len(msg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dec_input_0(dec_input_0), .dec_input_1(dec_input_1),
        .dec_input_2(dec_input_2), .dec_input_3(dec_input_3),
        .dec_wire_type(dec_wire_type), .dec_field_number(dec_field_number),
        .dec_bytes_read(dec_bytes_read), .dec_value_size(dec_value_size),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_field(hdr_field),
        .hdr_wire(hdr_wire), .hdr_len(hdr_len),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .pay_last(pay_last), .busy(busy), .done(done), .err(err),
        .err_code(err_code)
`ifdef FIELD_FILTER_EN
        ,
        .filter_en(1'b0), .filter_field(8'h00)
`endif
    );

    assign pay_data_unused = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Key decoder model: single-byte keys, single-byte length prefixes.
    always_comb begin
        dec_wire_type    = dec_input_0[2:0];
        dec_field_number = {4'b0000, dec_input_0[6:3]};
        dec_bytes_read   = dec_input_0[7] ? 8'd0 : 8'd1;
        dec_value_size   = 16'd0;
        if (!dec_input_0[7] && dec_input_0[2:0] == 3'd2) begin
            dec_value_size = {8'h00, dec_input_1};
            dec_bytes_read = 8'd2;
        end
    end

    int errs;
    int checks;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]       stim[$];
    logic [7:0]       got_pay[$];
    logic             got_last[$];
    logic [26:0]      got_hdr[$];
    logic [7:0]       exp_pay[$];
    logic             exp_last[$];
    int               idx;
    int               n_done;
    bit               ok;

    task automatic run_msg(input int len, input bit tog, input int hdly,
                           input bit stop_pay, output bit fin);
        int         hwait;
        bit         stall;
        logic [7:0] held;
        idx = 0;
        n_done = 0;
        hwait = 0;
        stall = 0;
        held = 8'h00;
        got_pay.delete();
        got_last.delete();
        got_hdr.delete();
        msg_len = LEN_W'(len);
        msg_start = 1'b1;
        @(negedge clock);
        msg_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = (idx < stim.size());
            in_data   = in_valid ? stim[idx] : 8'h00;
            pay_ready = stop_pay ? 1'b0 : (tog ? c[0] : 1'b1);
            hdr_ready = (hwait >= hdly);
            #1;
            if (stall) check("pay_hold", {23'd0, pay_valid, pay_data}, {23'd0, 1'b1, held});
            stall = pay_valid && !pay_ready;
            held  = pay_data;
            if (in_valid && in_ready) idx++;
            if (hdr_valid && hdr_ready) begin
                got_hdr.push_back({hdr_field, hdr_wire, hdr_len});
                hwait = 0;
            end else if (hdr_valid) begin
                hwait++;
            end
            if (pay_valid && pay_ready) begin
                got_pay.push_back(pay_data);
                got_last.push_back(pay_last);
            end
            if (done) n_done++;
            if (stop_pay && pay_valid) begin
                fin = 1'b1;
                return;
            end
            if (!busy) begin
                fin = 1'b1;
                return;
            end
            @(negedge clock);
        end
        fin = 1'b0;
    endtask

    task automatic check_hdr(input string t, input int i, input logic [7:0] f,
                             input logic [2:0] w, input logic [15:0] l);
        if (i < got_hdr.size()) check(t, {5'd0, got_hdr[i]}, {5'd0, f, w, l});
        else                    check(t, 32'd0, 32'd1);
    endtask

    task automatic check_pay(input string t);
        check({t, "_n"}, got_pay.size(), exp_pay.size());
        for (int i = 0; i < exp_pay.size(); i++) begin
            if (i < got_pay.size()) begin
                check({t, "_d"}, {23'd0, got_last[i], got_pay[i]},
                      {23'd0, exp_last[i], exp_pay[i]});
            end
        end
    endtask

    task automatic check_end(input string t, input int nh, input int nd,
                             input logic e, input logic [1:0] ec);
        check({t, "_hdrs"}, got_hdr.size(), nh);
        check({t, "_done"}, n_done, nd);
        check({t, "_err"}, {29'd0, e === err, err_code}, {29'd0, 1'b1, ec});
        check({t, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        errs = 0;
        checks = 0;
        reset = 1'b0;
        msg_start = 1'b0;
        msg_len = '0;
        in_valid = 1'b0;
        in_data = 8'h00;
        hdr_ready = 1'b0;
        pay_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", {busy, in_ready}, 2'b00);
        check("rst_hdr", {5'd0, hdr_valid, hdr_field, hdr_wire, hdr_len}, 32'd0);
        check("rst_pay", {pay_valid, pay_data, pay_last}, 10'd0);
        check("rst_stat", {done, err, err_code}, 4'd0);
        check("rst_win", {dec_input_3, dec_input_2, dec_input_1, dec_input_0}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // varint field
        stim = {8'h08, 8'h96, 8'h01};
        run_msg(3, 1'b0, 0, 1'b0, ok);
        check("t1_to", ok, 1'b1);
        check_hdr("t1_hdr", 0, 8'd1, 3'd0, 16'd0);
        exp_pay = {8'h96, 8'h01};
        exp_last = {1'b0, 1'b1};
        check_pay("t1_pay");
        check_end("t1", 1, 1, 1'b0, 2'd0);

        // length-delimited field
        stim = {8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
        run_msg(5, 1'b0, 0, 1'b0, ok);
        check("t2_to", ok, 1'b1);
        check_hdr("t2_hdr", 0, 8'd2, 3'd2, 16'd3);
        exp_pay = {8'h61, 8'h62, 8'h63};
        exp_last = {1'b0, 1'b0, 1'b1};
        check_pay("t2_pay");
        check_end("t2", 1, 1, 1'b0, 2'd0);

        // two fields, then the same message under backpressure
        for (int pass = 0; pass < 2; pass++) begin
            stim = {8'h0D, 8'h11, 8'hA2, 8'h33, 8'hC4, 8'h08, 8'h05};
            run_msg(7, pass[0], pass * 5, 1'b0, ok);
            check("t3_to", ok, 1'b1);
            check_hdr("t3_hdr0", 0, 8'd1, 3'd5, 16'd4);
            check_hdr("t3_hdr1", 1, 8'd1, 3'd0, 16'd0);
            exp_pay = {8'h11, 8'hA2, 8'h33, 8'hC4, 8'h05};
            exp_last = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            check_pay("t3_pay");
            check_end("t3", 2, 1, 1'b0, 2'd0);
        end

        // empty message
        stim.delete();
        run_msg(0, 1'b0, 0, 1'b0, ok);
        check("t4_to", ok, 1'b1);
        check_end("t4", 0, 1, 1'b0, 2'd0);

        // unsupported wire type, input drained
        stim = {8'h0B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_msg(6, 1'b0, 0, 1'b0, ok);
        check("t5_to", ok, 1'b1);
        check("t5_drain", idx, 6);
        check("t5_pay", got_pay.size(), 0);
        check_end("t5", 0, 0, 1'b1, 2'd2);

        // length prefix overruns message
        stim = {8'h12, 8'h05};
        run_msg(2, 1'b0, 0, 1'b0, ok);
        check("t6_to", ok, 1'b1);
        check_end("t6", 0, 0, 1'b1, 2'd3);

        // reset in the middle of a payload
        stim = {8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
        run_msg(5, 1'b0, 0, 1'b1, ok);
        check("t7_to", ok, 1'b1);
        reset = 1'b0;
        #1;
        check("t7_rst_busy", {busy, in_ready, hdr_valid, pay_valid}, 4'd0);
        check("t7_rst_out", {pay_data, pay_last, done, err, err_code}, 12'd0);
        check("t7_rst_win", {dec_input_3, dec_input_2, dec_input_1, dec_input_0}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        pay_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        stim = {8'h08, 8'h96, 8'h01};
        run_msg(3, 1'b0, 0, 1'b0, ok);
        check("t8_to", ok, 1'b1);
        check_hdr("t8_hdr", 0, 8'd1, 3'd0, 16'd0);
        exp_pay = {8'h96, 8'h01};
        exp_last = {1'b0, 1'b1};
        check_pay("t8_pay");
        check_end("t8", 1, 1, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
